ras: RTL and testbench

//  Return address stack for the fetch predictor. The fetch side pushes call return addresses and

---
 rtl/ras.sv | 97 +++++++++
 tb/tb_ras.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras.sv
// Return address stack for the fetch predictor, with checkpoint restore
// from the backend on a mispredict.
module ras #(
  parameter int RAS_ENTRIES      = 8,
  parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        pred_valid,
  input  logic                        pred_push,
  input  logic                        pred_pop,
  input  logic [RAS_TARGET_WIDTH-1:0] pred_push_target,
  output logic [RAS_TARGET_WIDTH-1:0] pred_ret_target,
  output logic                        pred_ret_valid,
  output logic [LOG_RAS_ENTRIES-1:0]  pred_ras_index,
  output logic [LOG_RAS_ENTRIES:0]    pred_ras_count,
  input  logic                        update_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  update_ras_index,
  input  logic [LOG_RAS_ENTRIES:0]    update_ras_count,
  input  logic                        update_push,
  input  logic                        update_pop,
  input  logic [RAS_TARGET_WIDTH-1:0] update_push_target
);

  localparam logic [LOG_RAS_ENTRIES:0] FULL_COUNT = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] entry [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  ptr, ptr_next;
  logic [LOG_RAS_ENTRIES:0]    count, count_next;

  logic                        op_push, op_pop;
  logic [LOG_RAS_ENTRIES-1:0]  base_ptr;
  logic [LOG_RAS_ENTRIES:0]    base_count;
  logic [RAS_TARGET_WIDTH-1:0] op_target;
  logic                        wr_en;
  logic [LOG_RAS_ENTRIES-1:0]  wr_idx;

  // A backend restore rebases the stack on its checkpoint and wins over any fetch access.
  always_comb begin
    op_push    = 1'b0;
    op_pop     = 1'b0;
    base_ptr   = ptr;
    base_count = count;
    op_target  = pred_push_target;
    if (update_valid) begin
      op_push    = update_push;
      op_pop     = update_pop;
      base_ptr   = update_ras_index;
      base_count = update_ras_count;
      op_target  = update_push_target;
    end else if (pred_valid) begin
      op_push = pred_push;
      op_pop  = pred_pop;
    end

    ptr_next   = base_ptr;
    count_next = base_count;
    wr_en      = 1'b0;
    wr_idx     = base_ptr;
    if (op_push && op_pop) begin
      // Co-routine jump: replace the top in place.
      wr_en = 1'b1;
      if (base_count == '0) count_next = 1;
    end else if (op_push) begin
      ptr_next = base_ptr + 1'b1;
      wr_idx   = ptr_next;
      wr_en    = 1'b1;
      if (base_count != FULL_COUNT) count_next = base_count + 1'b1;
    end else if (op_pop && base_count != '0) begin
      ptr_next   = base_ptr - 1'b1;
      count_next = base_count - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) entry[i] <= '0;
    end else begin
      ptr   <= ptr_next;
      count <= count_next;
      if (wr_en) entry[wr_idx] <= op_target;
    end
  end

  assign pred_ret_target = entry[ptr];
  assign pred_ret_valid  = (count != '0);
  assign pred_ras_index  = ptr;
  assign pred_ras_count  = count;

  // A checkpoint can never hold more than a full stack.
  update_count_legal: assert property (@(posedge CLK) disable iff (!nRST)
    update_valid |-> (update_ras_count <= FULL_COUNT));

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus randomized traffic
// compared against a simple stack model.
module tb_ras;

  localparam int N = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pred_valid, pred_push, pred_pop;
  logic [30:0] pred_push_target, pred_ret_target;
  logic        pred_ret_valid;
  logic [2:0]  pred_ras_index;
  logic [3:0]  pred_ras_count;
  logic        update_valid, update_push, update_pop;
  logic [2:0]  update_ras_index;
  logic [3:0]  update_ras_count;
  logic [30:0] update_push_target;

  int testCount = 0;
  int failCount = 0;

  logic [30:0] mEntry [N];
  int          mPtr, mCnt;
  logic [30:0] lastRet;
  logic        lastValid;
  int          ckIdx[$], ckCnt[$];

  ras dut (
    .CLK(CLK), .nRST(nRST),
    .pred_valid(pred_valid), .pred_push(pred_push), .pred_pop(pred_pop),
    .pred_push_target(pred_push_target), .pred_ret_target(pred_ret_target),
    .pred_ret_valid(pred_ret_valid), .pred_ras_index(pred_ras_index),
    .pred_ras_count(pred_ras_count),
    .update_valid(update_valid), .update_ras_index(update_ras_index),
    .update_ras_count(update_ras_count), .update_push(update_push),
    .update_pop(update_pop), .update_push_target(update_push_target)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    mPtr = 0;
    mCnt = 0;
    for (int i = 0; i < N; i++) mEntry[i] = '0;
  endfunction

  // Stack semantics applied to whichever base (live state or checkpoint) is active.
  function automatic void modelStep(bit pv, bit pp, bit po, logic [30:0] pt,
                                    bit uv, int ui, int uc, bit up, bit uo, logic [30:0] ut);
    int bp, bc;
    bit push, pop;
    logic [30:0] t;
    if (uv) begin
      bp = ui; bc = uc; push = up; pop = uo; t = ut;
    end else if (pv) begin
      bp = mPtr; bc = mCnt; push = pp; pop = po; t = pt;
    end else return;
    if (push && pop) begin
      mEntry[bp] = t;
      mPtr = bp;
      mCnt = (bc > 0) ? bc : 1;
    end else if (push) begin
      mPtr = (bp + 1) % N;
      mEntry[mPtr] = t;
      mCnt = (bc < N) ? bc + 1 : N;
    end else if (pop && bc > 0) begin
      mPtr = (bp + N - 1) % N;
      mCnt = bc - 1;
    end else begin
      mPtr = bp;
      mCnt = bc;
    end
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_target"}, 32'(pred_ret_target), 32'(mEntry[mPtr]));
    checkOutput({tag, "_valid"},  32'(pred_ret_valid),  32'(mCnt != 0));
    checkOutput({tag, "_index"},  32'(pred_ras_index),  32'(mPtr));
    checkOutput({tag, "_count"},  32'(pred_ras_count),  32'(mCnt));
  endtask

  // Drive one cycle at the falling edge, check pre-op outputs, commit at the rising edge.
  task automatic applyStimulus(input bit pv, input bit pp, input bit po, input logic [30:0] pt,
                               input bit uv, input int ui, input int uc, input bit up,
                               input bit uo, input logic [30:0] ut);
    pred_valid = pv; pred_push = pp; pred_pop = po; pred_push_target = pt;
    update_valid = uv; update_ras_index = 3'(ui); update_ras_count = 4'(uc);
    update_push = up; update_pop = uo; update_push_target = ut;
    #1;
    checkState("cyc");
    lastRet   = pred_ret_target;
    lastValid = pred_ret_valid;
    ckIdx.push_back(mPtr);
    ckCnt.push_back(mCnt);
    @(posedge CLK);
    modelStep(pv, pp, po, pt, uv, ui, uc, up, uo, ut);
    @(negedge CLK);
  endtask

  task automatic push(input logic [30:0] t);
    applyStimulus(1, 1, 0, t, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic pop();
    applyStimulus(1, 0, 1, '0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic doReset();
    nRST = 1'b0;
    pred_valid = 0; pred_push = 0; pred_pop = 0; pred_push_target = '0;
    update_valid = 0; update_ras_index = '0; update_ras_count = '0;
    update_push = 0; update_pop = 0; update_push_target = '0;
    modelReset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    checkOutput("reset_target", 32'(pred_ret_target), 32'h0);
    checkOutput("reset_valid",  32'(pred_ret_valid),  32'h0);
    checkOutput("reset_index",  32'(pred_ras_index),  32'h0);
    checkOutput("reset_count",  32'(pred_ras_count),  32'h0);

    push(31'h100); push(31'h200);
    pop();
    checkOutput("t1_pop1_target", 32'(lastRet), 32'h200);
    checkOutput("t1_pop1_valid",  32'(lastValid), 32'h1);
    pop();
    checkOutput("t1_pop2_target", 32'(lastRet), 32'h100);
    pop();
    checkOutput("t1_pop3_valid", 32'(lastValid), 32'h0);
    checkOutput("t1_pop3_index", 32'(pred_ras_index), 32'h0);
    checkOutput("t1_pop3_count", 32'(pred_ras_count), 32'h0);

    doReset();
    for (int i = 0; i < 10; i++) push(31'(32'h1000 + i));
    checkOutput("t2_full_count", 32'(pred_ras_count), 32'd8);
    for (int i = 9; i >= 2; i--) begin
      pop();
      checkOutput("t2_pop_target", 32'(lastRet), 32'h1000 + 32'(i));
    end
    pop();
    checkOutput("t2_empty_valid", 32'(lastValid), 32'h0);

    doReset();
    push(31'hA); push(31'hB);
    applyStimulus(1, 1, 1, 31'hC, 0, 0, 0, 0, 0, '0);
    checkOutput("t3_coroutine_target", 32'(lastRet), 32'hB);
    pop();
    checkOutput("t3_pop_target", 32'(lastRet), 32'hC);
    checkOutput("t3_count", 32'(pred_ras_count), 32'd1);

    // X lands in A's old slot, so the restored top reads X rather than A.
    doReset();
    push(31'hA); push(31'hB);
    pop(); pop();
    push(31'h58);
    applyStimulus(0, 0, 0, '0, 1, 2, 2, 0, 1, '0);
    pop();
    checkOutput("t4_restore_target", 32'(lastRet), 32'h58);
    checkOutput("t4_restore_valid",  32'(lastValid), 32'h1);

    doReset();
    push(31'hA);
    applyStimulus(1, 1, 0, 31'h59, 1, 1, 1, 1, 0, 31'h5A);
    checkOutput("t5_top", 32'(pred_ret_target), 32'h5A);
    checkOutput("t5_count", 32'(pred_ras_count), 32'd2);
    pop();
    pop();
    checkOutput("t5_below", 32'(lastRet), 32'hA);

    doReset();
    for (int i = 0; i < 5; i++) push(31'(32'h300 + i));
    checkOutput("t6_count5", 32'(pred_ras_count), 32'd5);
    nRST = 1'b0;
    #1;
    checkOutput("t6_async_target", 32'(pred_ret_target), 32'h0);
    checkOutput("t6_async_valid",  32'(pred_ret_valid),  32'h0);
    checkOutput("t6_async_index",  32'(pred_ras_index),  32'h0);
    checkOutput("t6_async_count",  32'(pred_ras_count),  32'h0);
    modelReset();
    @(negedge CLK);
    nRST = 1'b1;
    pop();
    checkOutput("t6_pop_valid", 32'(lastValid), 32'h0);

    doReset();
    ckIdx.delete();
    ckCnt.delete();
    for (int n = 0; n < 600; n++) begin
      bit uv;
      int k;
      uv = ($urandom_range(0, 7) == 0) && (ckIdx.size() > 0);
      k  = (ckIdx.size() > 16) ? $urandom_range(ckIdx.size() - 16, ckIdx.size() - 1)
                               : $urandom_range(0, (ckIdx.size() > 0) ? ckIdx.size() - 1 : 0);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                    31'($urandom), uv, uv ? ckIdx[k] : 0, uv ? ckCnt[k] : 0,
                    $urandom_range(0, 1), $urandom_range(0, 1), 31'($urandom));
    end
    checkState("final");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
